// File: rtl/dmem_pkg.sv
// Shared types and defaults for the posted-store data memory.
// A FIFO entry holds the word index of a pending store and its data.
package dmem_pkg;

  localparam int INDEX_W = 30;
  localparam logic [31:0] DONE_ADDR_DEFAULT = 32'd252;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [31:0]        data;
  } fifo_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular buffer of posted stores.
// Exposes every slot plus a per-slot valid bit so the parent can forward stores to loads.
module store_fifo
  import dmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  fifo_entry_t                         push_entry,
  input  logic                                pop,
  output logic [$clog2(FIFO_DEPTH)-1:0]       rd_ptr,
  output logic [$clog2(FIFO_DEPTH):0]         count,
  output logic                                full,
  output logic                                empty,
  output fifo_entry_t [FIFO_DEPTH-1:0]        entries,
  output logic [FIFO_DEPTH-1:0]               entry_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  fifo_entry_t [FIFO_DEPTH-1:0] slots;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot storage carries no reset; the valid bits define what is live.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_entry;
  end

  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
  end

  assign entries = slots;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/dmem_write_buffer.sv
// Data memory with a posted-store FIFO, store-to-load forwarding and a sticky
// end-of-program status register at DONE_ADDR.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] DONE_ADDR  = DONE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic [7:0]  Score
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0] ram [DEPTH];

  logic [AW-1:0] idx;
  logic          is_done, accept, push, pop, done_store;
  logic          full, empty;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW-1:0] slot;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  fifo_entry_t   push_entry;
  fifo_entry_t [FIFO_DEPTH-1:0] entries;
  logic [FIFO_DEPTH-1:0]        entry_valid;

  assign idx     = DataAdr[AW+1:2];
  assign is_done = (DataAdr == DONE_ADDR);

  // The status store waits for an empty FIFO so Done implies every earlier store is in RAM.
  assign Stall      = MemWrite & (full | (is_done & ~empty));
  assign accept     = MemWrite & ~Stall;
  assign push       = accept & ~is_done & ~reset;
  assign done_store = accept & is_done;
  assign pop        = ~empty & ~MemRead & ~reset;
  assign push_entry = '{index: INDEX_W'(idx), data: WriteData};

  store_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .entry_valid(entry_valid)
  );

  always_ff @(posedge clk) begin
    if (pop) ram[entries[rd_ptr].index[AW-1:0]] <= entries[rd_ptr].data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Done  <= 1'b0;
      Score <= '0;
    end else if (done_store) begin
      Done  <= 1'b1;
      Score <= WriteData[7:0];
    end
  end

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if (entry_valid[slot] && entries[slot].index == INDEX_W'(idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[slot].data;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (is_done)      ReadData = {23'b0, Done, Score};
      else if (fwd_hit) ReadData = fwd_data;
      else              ReadData = ram[idx];
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed self-checking bench for dmem_write_buffer.
// Inputs change 1ns after a rising edge; combinational outputs are checked 1ns later.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] DataAdr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Done;
  logic [7:0]  Score;

  int checks   = 0;
  int failures = 0;
  int stallCycles;

  dmem_write_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .Done     (Done),
    .Score    (Score)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] adr, input logic [31:0] wd);
    MemWrite  = we;
    MemRead   = re;
    DataAdr   = adr;
    WriteData = wd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("rst_stall", {31'b0, Stall}, 32'd0);
    checkOutput("rst_done", {31'b0, Done}, 32'd0);
    checkOutput("rst_score", {24'b0, Score}, 32'd0);
    checkOutput("rst_rdata", ReadData, 32'd0);

    // Forwarding, then RAM read-back
    applyStimulus(1, 0, 32'h10, 32'h11);
    checkOutput("t2_stall", {31'b0, Stall}, 32'd0);
    step();
    applyStimulus(0, 1, 32'h10, 32'h0);
    checkOutput("t2_fwd0", ReadData, 32'h11);
    step();
    checkOutput("t2_fwd1", ReadData, 32'h11);
    step();
    applyStimulus(0, 0, 32'h10, 32'h0);
    checkOutput("t2_noread", ReadData, 32'h0);
    step();
    applyStimulus(0, 1, 32'h10, 32'h0);
    checkOutput("t2_ram", ReadData, 32'h11);
    step();

    // Fill the FIFO while loads block the drain
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
      checkOutput($sformatf("t3_stall%0d", i), {31'b0, Stall}, 32'd0);
      step();
    end
    applyStimulus(1, 1, 32'h50, 32'h104);
    checkOutput("t3_full0", {31'b0, Stall}, 32'd1);
    step();
    checkOutput("t3_full1", {31'b0, Stall}, 32'd1);
    step();
    applyStimulus(1, 0, 32'h50, 32'h104);
    checkOutput("t3_samecycle", {31'b0, Stall}, 32'd1);
    step();
    checkOutput("t3_freed", {31'b0, Stall}, 32'd0);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0);
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 32'h40 + 32'(4 * i), 32'h0);
      checkOutput($sformatf("t3_ram%0d", i), ReadData, 32'h100 + 32'(i));
      step();
    end

    // Youngest matching entry wins
    applyStimulus(1, 1, 32'h20, 32'hA);
    step();
    applyStimulus(1, 1, 32'h20, 32'hB);
    step();
    applyStimulus(0, 1, 32'h20, 32'h0);
    checkOutput("t4_youngest", ReadData, 32'hB);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0);
    repeat (4) step();
    applyStimulus(0, 1, 32'h20, 32'h0);
    checkOutput("t4_ram", ReadData, 32'hB);
    step();

    // Status store waits for an empty FIFO
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'h60 + 32'(4 * i), 32'(i + 1));
      step();
    end
    applyStimulus(1, 0, 32'd252, 32'd22);
    stallCycles = 0;
    while (Stall && stallCycles < 10) begin
      stallCycles++;
      step();
    end
    checkOutput("t5_stallcycles", 32'(stallCycles), 32'd3);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("t5_done", {31'b0, Done}, 32'd1);
    checkOutput("t5_score", {24'b0, Score}, 32'd22);
    applyStimulus(0, 1, 32'd252, 32'h0);
    checkOutput("t5_status", ReadData, 32'h116);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h60 + 32'(4 * i), 32'h0);
      checkOutput($sformatf("t5_ram%0d", i), ReadData, 32'(i + 1));
      step();
    end
    applyStimulus(1, 0, 32'd252, 32'h5A);
    checkOutput("t5_redone_stall", {31'b0, Stall}, 32'd0);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("t5_redone_done", {31'b0, Done}, 32'd1);
    checkOutput("t5_redone_score", {24'b0, Score}, 32'h5A);

    // Reset discards pending entries but keeps drained RAM words
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h70 + 32'(4 * i), 32'hAA0 + 32'(i));
      step();
    end
    applyStimulus(0, 0, 32'h0, 32'h0);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'h70 + 32'(4 * i), 32'hB0 + 32'(i));
      step();
    end
    applyStimulus(0, 1, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("t6_done", {31'b0, Done}, 32'd0);
    checkOutput("t6_score", {24'b0, Score}, 32'd0);
    applyStimulus(1, 0, 32'd252, 32'h77);
    checkOutput("t6_empty", {31'b0, Stall}, 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h70 + 32'(4 * i), 32'h0);
      checkOutput($sformatf("t6_ram%0d", i), ReadData, 32'hAA0 + 32'(i));
      step();
    end

    applyStimulus(0, 0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
